// File: rtl/game_report_tx_pkg.sv
// Shared definitions for the game telemetry transmitter: game state codes,
// packet length, snapshot record and packet byte builder.
// Build option: define REPORT_CSUM_EN to append an XOR checksum byte (7-byte
// packet); leave it undefined for the 6-byte packet without checksum.
package game_pkg;

    localparam logic [1:0] ST_START      = 2'd0;
    localparam logic [1:0] ST_END        = 2'd1;
    localparam logic [1:0] ST_GAME       = 2'd2;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef REPORT_CSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    // The sync byte goes out while the FSM is in SEND, so the snapshot is
    // taken on the edge that leaves IDLE (or that ends the previous packet).
    typedef enum logic [0:0] {
        PS_IDLE = 1'b0,
        PS_SEND = 1'b1
    } pkt_state_t;

    typedef struct packed {
        logic [1:0]  state;
        logic [11:0] bird_y;
        logic [11:0] tube_x;
        logic [11:0] tube_h;
    } snap_t;

    function automatic logic [7:0] csum8(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [7:0] b3, input logic [7:0] b4,
                                         input logic [7:0] b5);
        return b1 ^ b2 ^ b3 ^ b4 ^ b5;
    endfunction

    function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input snap_t s,
                                            input logic [7:0] sync);
        logic [7:0] b1, b2, b3, b4, b5;
        logic [7:0] res;
        b1 = {2'b00, s.state, s.bird_y[11:8]};
        b2 = s.bird_y[7:0];
        b3 = {s.tube_h[11:8], s.tube_x[11:8]};
        b4 = s.tube_x[7:0];
        b5 = s.tube_h[7:0];
        case (idx)
            3'd0:    res = sync;
            3'd1:    res = b1;
            3'd2:    res = b2;
            3'd3:    res = b3;
            3'd4:    res = b4;
            3'd5:    res = b5;
`ifdef REPORT_CSUM_EN
            3'd6:    res = csum8(b1, b2, b3, b4, b5);
`endif
            default: res = 8'hFF;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/game_report_tx_if.sv
// Game-side inputs and UART-side outputs of the telemetry transmitter.
interface game_report_tx_if;
    logic        vs_in;
    logic [1:0]  state;
    logic [11:0] bird_loc_y;
    logic [11:0] tube1_x;
    logic [11:0] tube1_h;
    logic        tx;
    logic        busy;
    logic [15:0] pkt_cnt;

    modport master (output vs_in, state, bird_loc_y, tube1_x, tube1_h,
                    input  tx, busy, pkt_cnt);
    modport slave  (input  vs_in, state, bird_loc_y, tube1_x, tube1_h,
                    output tx, busy, pkt_cnt);
endinterface

// File: rtl/game_report_tx_uart_byte_tx.sv
// 8N1 byte serializer: start bit, d0..d7, stop bit, each CYCLES_PER_BIT clocks.
// Ready in idle and on the last clock of the stop bit, so bytes chain gap-free.
module uart_byte_tx #(
    parameter int CLK_FRE_HZ = 27_000_000,
    parameter int BAUD       = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic       o_tx_pin
);
    localparam int CPB = CLK_FRE_HZ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

    logic             r_busy;
    logic [3:0]       r_bit_idx;
    logic [CNT_W-1:0] r_cyc;
    logic [7:0]       r_data;
    logic             r_tx;
    logic             w_bit_end;
    logic             w_last_bit_end;
    logic             w_accept;

    assign w_bit_end      = r_busy & (r_cyc == CNT_LAST);
    assign w_last_bit_end = w_bit_end & (r_bit_idx == 4'd9);
    assign o_data_ready   = ~r_busy | w_last_bit_end;
    assign w_accept       = i_data_valid & o_data_ready;
    assign o_tx_pin       = r_tx;

    // Bit timing and shift-out; a new byte takes priority over returning to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_bit_idx <= 4'd0;
            r_cyc     <= '0;
            r_data    <= 8'h00;
            r_tx      <= 1'b1;
        end else if (w_accept) begin
            r_busy    <= 1'b1;
            r_bit_idx <= 4'd0;
            r_cyc     <= '0;
            r_data    <= i_data;
            r_tx      <= 1'b0;
        end else if (w_last_bit_end) begin
            r_busy <= 1'b0;
            r_cyc  <= '0;
            r_tx   <= 1'b1;
        end else if (w_bit_end) begin
            r_cyc     <= '0;
            r_bit_idx <= r_bit_idx + 4'd1;
            r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : r_data[r_bit_idx[2:0]];
        end else if (r_busy) begin
            r_cyc <= r_cyc + CNT_W'(1);
        end
    end
endmodule

// File: rtl/game_report_tx.sv
// Telemetry return path: snapshots game state and tube geometry every
// FRAME_DIV vsync falls or on any game-state change and sends it as UART.
// Build option: REPORT_CSUM_EN adds the XOR checksum byte (see game_pkg).
module game_report_tx
    import game_pkg::*;
#(
    parameter int         CLK_FRE_HZ = 27_000_000,
    parameter int         BAUD       = 115200,
    parameter int         FRAME_DIV  = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input logic             clk,
    input logic             rst_n,
    game_report_tx_if.slave bus
);
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

    logic        r_vs;
    logic [7:0]  r_div;
    logic [1:0]  r_prev_state;
    pkt_state_t  r_pst, w_pst_nxt;
    logic [2:0]  r_byte_idx, w_byte_idx_nxt;
    logic        r_pending, w_pending_nxt;
    logic        r_busy, w_busy_nxt;
    snap_t       r_snap, w_snap_nxt, w_snap_in;
    logic [15:0] r_pkt_cnt;
    logic        w_pkt_done;
    logic        w_vs_fall, w_per_trig, w_st_trig, w_trig;
    logic [7:0]  w_ser_data;
    logic        w_ser_valid, w_ser_ready, w_tx;

    assign w_vs_fall  = r_vs & ~bus.vs_in;
    assign w_per_trig = w_vs_fall & (r_div == DIV_LAST);
    assign w_st_trig  = (bus.state != r_prev_state);
    assign w_trig     = w_per_trig | w_st_trig;
    assign w_snap_in  = {bus.state, bus.bird_loc_y, bus.tube1_x, bus.tube1_h};

    // vsync edge history, frame divider and previous game state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs         <= 1'b0;
            r_div        <= 8'd0;
            r_prev_state <= ST_START;
        end else begin
            r_vs         <= bus.vs_in;
            r_prev_state <= bus.state;
            if (w_vs_fall) begin
                r_div <= w_per_trig ? 8'd0 : r_div + 8'd1;
            end
        end
    end

    // Packet FSM: start on trigger, walk the bytes, chain a pending packet.
    always_comb begin
        w_pst_nxt      = r_pst;
        w_byte_idx_nxt = r_byte_idx;
        w_pending_nxt  = r_pending;
        w_busy_nxt     = r_busy;
        w_snap_nxt     = r_snap;
        w_ser_valid    = 1'b0;
        w_ser_data     = SYNC_BYTE;
        w_pkt_done     = 1'b0;
        case (r_pst)
            PS_IDLE: begin
                if (w_trig) begin
                    w_snap_nxt     = w_snap_in;
                    w_ser_valid    = 1'b1;
                    w_byte_idx_nxt = 3'd0;
                    w_busy_nxt     = 1'b1;
                    w_pst_nxt      = PS_SEND;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            PS_SEND: begin
                if (w_ser_ready && (r_byte_idx == LAST_IDX)) begin
                    w_pkt_done = 1'b1;
                    if (r_pending || w_trig) begin
                        w_snap_nxt     = w_snap_in;
                        w_ser_valid    = 1'b1;
                        w_byte_idx_nxt = 3'd0;
                        w_pending_nxt  = 1'b0;
                    end else begin
                        w_pst_nxt  = PS_IDLE;
                        w_busy_nxt = 1'b0;
                    end
                end else if (w_ser_ready) begin
                    w_ser_valid    = 1'b1;
                    w_ser_data     = pkt_byte(r_byte_idx + 3'd1, r_snap, SYNC_BYTE);
                    w_byte_idx_nxt = r_byte_idx + 3'd1;
                    w_pending_nxt  = r_pending | w_trig;
                end else begin
                    w_pending_nxt = r_pending | w_trig;
                end
            end
            default: begin
                w_pst_nxt  = PS_IDLE;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Packet FSM state, snapshot and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pst      <= PS_IDLE;
            r_byte_idx <= 3'd0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_snap     <= '0;
        end else begin
            r_pst      <= w_pst_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_pending  <= w_pending_nxt;
            r_busy     <= w_busy_nxt;
            r_snap     <= w_snap_nxt;
        end
    end

    // Completed-packet counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= 16'd0;
        end else if (w_pkt_done) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    uart_byte_tx #(
        .CLK_FRE_HZ (CLK_FRE_HZ),
        .BAUD       (BAUD)
    ) u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (w_ser_data),
        .i_data_valid (w_ser_valid),
        .o_data_ready (w_ser_ready),
        .o_tx_pin     (w_tx)
    );

    assign bus.tx      = w_tx;
    assign bus.busy    = r_busy;
    assign bus.pkt_cnt = r_pkt_cnt;
endmodule
